chesssoc_button_pio: RTL and testbench
======================================

CHESSSOC_BUTTON_PIO -- requirements
Module: chesssoc_button_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of input channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a change, 0..65535; 0 bypasses the debouncer.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = inputs inverted after synchronisation, so a pressed key reads 1.
REQ-004 Parameter EDGE_MODE, default 0: edge type captured; 0 rising, 1 falling, 2 both, applied to the debounced post-inversion value.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous key/switch inputs.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Each in_port bit SHALL pass a 2-flop synchroniser (s1, s2), then optional inversion per ACTIVE_LOW.
REQ-015 Per channel, a debounce counter SHALL reset to 0 whenever the synchronised bit equals the stable bit.
REQ-016 Per channel, when the synchronised bit differs from the stable bit and the counter equals DEBOUNCE_CYCLES-1, the stable bit SHALL take the new value and the counter SHALL return to 0; otherwise the counter SHALL increment.
REQ-017 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap past DEBOUNCE_CYCLES-1.
REQ-018 With DEBOUNCE_CYCLES=0, the stable bit SHALL equal the synchronised bit, delayed by one register.
REQ-019 Latency: a pin change sampled into s1 at edge N SHALL appear in the stable bit at edge N+1+DEBOUNCE_CYCLES (N+2 when bypassed).
REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL leave the stable bit unchanged.
REQ-021 Register map: addr 0 = data (RO, stable bits); addr 1 = reserved (reads 0, writes ignored); addr 2 = irq mask (RW, WIDTH bits); addr 3 = edge capture (read, write-1-to-clear).
REQ-022 An edge-capture bit SHALL set on the same edge on which its stable bit makes a transition of the type selected by EDGE_MODE.
REQ-023 A write to addr 3 (chipselect=1, write_n=0) SHALL clear every capture bit whose writedata bit is 1.
REQ-024 If a set and a clear hit the same capture bit in the same cycle, set SHALL win.
REQ-025 A write to addr 2 SHALL load mask from writedata[WIDTH-1:0] on that edge.
REQ-026 irq SHALL equal OR(edge_capture & mask), decoded from registers with no extra delay.
REQ-027 Every cycle, readdata SHALL register the address-selected value, zero-extended to 32 bits, independent of chipselect; read latency is 1 cycle.
REQ-028 Bits [31:WIDTH] of every readable register SHALL read 0.

Reset
REQ-029 While reset=1 at a clk edge: s1, s2, stable, counters, mask, edge capture and readdata SHALL become 0, and irq SHALL be 0 one edge later.
REQ-030 No edge SHALL be captured on the first cycles after reset, even if the synchronised input is already 1; the debouncer SHALL treat it as a normal change.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count.

Verification
REQ-032 DEBOUNCE_CYCLES=4, ACTIVE_LOW=1: drive in_port[0] 1->0 and hold -> data reads 0x1 with stable set at edge N+5; edge_capture=0x1.
REQ-033 DEBOUNCE_CYCLES=4: pulse in_port[1] low for 3 cycles -> data stays 0x0, edge_capture stays 0x0.
REQ-034 mask=0x1, capture bit 0 set -> irq=1; write 0x1 to addr 3 -> capture=0, irq=0 next cycle; with mask=0x0, irq stays 0 throughout.
REQ-035 EDGE_MODE=2: press then release key 2 -> capture bit 2 set on both edges; W1C issued in the same cycle as the release edge -> bit remains 1.
REQ-036 Write 0xFFFFFFFF to addr 1 and 2 (WIDTH=4) -> addr 1 reads 0x0, addr 2 reads 0xF.
REQ-037 Assert reset during debounce count 2 -> all registers 0; after release, the change requires 4 full stable cycles again.

Source files
------------

// File: rtl/chesssoc_button_pio.sv
// chesssoc_button_pio: synchronised, debounced key/switch inputs with
// edge capture and a level interrupt behind an Avalon-MM slave.
module chesssoc_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] stable_nxt_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] cap_nxt_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clear_s;
    logic             wr_s;
    logic             unused_s;

    // Upper writedata bits carry no register state.
    assign unused_s = ^writedata;
    assign wr_s     = chipselect & ~write_n;

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r <= in_port;
            s2_r <= s1_r;
        end
    end

    assign sync_s = (ACTIVE_LOW != 32'sd0) ? ~s2_r : s2_r;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_nxt_s = sync_s;
        end else begin : g_debounce
            localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

            logic [CW-1:0] cnt_r     [WIDTH];
            logic [CW-1:0] cnt_nxt_s [WIDTH];

            // Per channel: restart on agreement, accept the new level after the last count.
            always_comb begin
                for (int i = 0; i < WIDTH; i++) begin
                    stable_nxt_s[i] = stable_r[i];
                    cnt_nxt_s[i]    = '0;
                    if (sync_s[i] == stable_r[i]) begin
                        cnt_nxt_s[i] = '0;
                    end else if (cnt_r[i] == CNT_LAST) begin
                        stable_nxt_s[i] = sync_s[i];
                        cnt_nxt_s[i]    = '0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
            end

            // Debounce counter state.
            always_ff @(posedge clk) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (reset) begin
                        cnt_r[i] <= '0;
                    end else begin
                        cnt_r[i] <= cnt_nxt_s[i];
                    end
                end
            end
        end
    endgenerate

    // Edge detection on the debounced value; a same-cycle set overrides the clear.
    always_comb begin
        set_s   = ~stable_r & stable_nxt_s;
        clear_s = '0;
        case (EDGE_MODE)
            32'sd1:  set_s = stable_r & ~stable_nxt_s;
            32'sd2:  set_s = stable_r ^ stable_nxt_s;
            default: set_s = ~stable_r & stable_nxt_s;
        endcase
        if (wr_s && (address == 2'd3)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = '0;
        end
        cap_nxt_s = (cap_r & ~clear_s) | set_s;
    end

    // Architectural registers and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r <= '0;
            mask_r   <= '0;
            cap_r    <= '0;
            readdata <= 32'd0;
        end else begin
            stable_r <= stable_nxt_s;
            cap_r    <= cap_nxt_s;
            if (wr_s && (address == 2'd2)) begin
                mask_r <= writedata[WIDTH-1:0];
            end else begin
                mask_r <= mask_r;
            end
            case (address)
                2'd0:    readdata <= 32'(stable_r);
                2'd1:    readdata <= 32'd0;
                2'd2:    readdata <= 32'(mask_r);
                2'd3:    readdata <= 32'(cap_r);
                default: readdata <= 32'd0;
            endcase
        end
    end

    assign irq = |(cap_r & mask_r);

endmodule

// File: tb/tb_chesssoc_button_pio.sv
// Scoreboard bench for chesssoc_button_pio: a behavioural model queues the
// expected readdata/irq for every cycle and a negedge monitor compares them.
module tb_chesssoc_button_pio;
    localparam int W   = 4;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [W-1:0] pin;
    logic [31:0] readdata;
    logic        irq;

    chesssoc_button_pio #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1), .EDGE_MODE(2)
    ) dut (
        .clk(clk), .reset(rst), .address(addr), .chipselect(cs),
        .write_n(wn), .writedata(wd), .in_port(pin),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: pins seen by the two synchroniser stages, accepted levels,
    // and the last DEB synchronised samples.
    logic [W-1:0] m_p1, m_p2, m_stable, m_mask, m_cap;
    logic [W-1:0] m_hist[$];
    logic [31:0]  m_rd;

    task automatic model_step();
        logic [W-1:0] flip;
        logic [W-1:0] clr;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_stable = '0; m_mask = '0; m_cap = '0;
            m_rd = 32'd0;
            m_hist.delete();
            return;
        end
        m_hist.push_back(~m_p2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        // A channel changes once its last DEB samples all disagree with its level.
        flip = '0;
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < W; i++) begin
                flip[i] = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) flip[i] = 1'b0;
            end
        end
        case (addr)
            2'd0: m_rd = 32'(m_stable);
            2'd2: m_rd = 32'(m_mask);
            2'd3: m_rd = 32'(m_cap);
            default: m_rd = 32'd0;
        endcase
        clr   = (cs && !wn && addr == 2'd3) ? wd[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | flip;
        if (cs && !wn && addr == 2'd2) m_mask = wd[W-1:0];
        m_stable = m_stable ^ flip;
        m_p2 = m_p1;
        m_p1 = pin;
    endtask

    task automatic push(input bit is_irq, input logic [31:0] exp, input string name);
        chk_t e;
        e.due = cyc + 1; e.is_irq = is_irq; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        model_step();
        push(1'b0, m_rd, $sformatf("rd_addr%0d", addr));
        push(1'b1, {31'd0, |(m_cap & m_mask)}, "irq_model");
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic [31:0] exp, input string name);
        push(1'b0, exp, name);
    endtask

    task automatic expect_irq(input logic exp, input string name);
        push(1'b1, {31'd0, exp}, name);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wd = d; cs = 1'b1; wn = 1'b0;
        tick();
        cs = 1'b0; wn = 1'b1; wd = $urandom;
    endtask

    chk_t        mon_e;
    logic [31:0] mon_act;
    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = mon_e.is_irq ? {31'd0, irq} : readdata;
            checks++;
            if (mon_e.due != cyc) begin
                errors++;
                $display("FAIL %s: check missed at cycle %0d (due %0d)", mon_e.name, cyc, mon_e.due);
            end else if (mon_act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: actual=%h expected=%h (cycle %0d)", mon_e.name, mon_act, mon_e.exp, cyc);
            end
        end
    end

    initial begin
        rst = 1'b1; addr = 2'd0; cs = 1'b0; wn = 1'b1; wd = 32'd0; pin = 4'hF;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin addr = 2'(k); tick(); end
        addr = 2'd0; expect_rd(32'h0, "data_after_reset"); tick();

        // Glitch shorter than the debounce window on key 1.
        pin = 4'hD; repeat (3) tick();
        pin = 4'hF; repeat (8) tick();
        expect_rd(32'h0, "glitch_data"); tick();
        addr = 2'd3; expect_rd(32'h0, "glitch_capture"); tick();

        // Press key 0: stable at edge N+5, visible on readdata one edge later.
        pin = 4'hE; addr = 2'd0;
        repeat (5) tick();
        expect_rd(32'h0, "press_before_latency"); tick();
        expect_rd(32'h1, "press_at_latency"); tick();
        repeat (3) tick();
        addr = 2'd3; expect_rd(32'h1, "press_capture"); expect_irq(1'b0, "irq_masked"); tick();

        // Mask, interrupt, and write-1-to-clear.
        expect_irq(1'b1, "irq_on_mask"); wr(2'd2, 32'h1);
        expect_irq(1'b0, "irq_after_w1c"); wr(2'd3, 32'h1);
        addr = 2'd3; expect_rd(32'h0, "capture_after_w1c"); tick();

        // Key 2 press then release; clear collides with the release edge.
        pin = 4'hA; repeat (8) tick();
        addr = 2'd3; expect_rd(32'h4, "both_edge_press"); tick();
        wr(2'd3, 32'h4);
        pin = 4'hE; addr = 2'd0; repeat (5) tick();
        wr(2'd3, 32'h4);
        addr = 2'd3; expect_rd(32'h4, "set_beats_clear"); tick();

        // Reserved register and mask width.
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF);
        addr = 2'd1; expect_rd(32'h0, "reserved_reads_zero"); tick();
        addr = 2'd2; expect_rd(32'hF, "mask_width"); expect_irq(1'b1, "irq_full_mask"); tick();

        // Reset during a debounce count on key 3 discards the partial count.
        pin = 4'h6; addr = 2'd0; repeat (4) tick();
        rst = 1'b1; addr = 2'd2;
        expect_rd(32'h0, "reset_clears_read"); expect_irq(1'b0, "reset_clears_irq"); tick();
        rst = 1'b0; addr = 2'd0;
        repeat (3) tick();
        expect_rd(32'h0, "recount_early"); tick();
        expect_rd(32'h9, "recount_done"); tick();
        wr(2'd3, 32'hF);

        // Randomised traffic: slowly toggling pins, random reads and writes.
        for (int k = 0; k < 500; k++) begin
            for (int b = 0; b < W; b++) if ($urandom_range(5, 0) == 0) pin[b] = ~pin[b];
            addr = 2'($urandom_range(3, 0));
            cs   = ($urandom_range(3, 0) == 0);
            wn   = ($urandom_range(1, 0) == 0);
            wd   = $urandom;
            tick();
        end
        cs = 1'b0; wn = 1'b1;

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
